// File: rtl/instr_axilite_regs_if.sv
// AXI4-Lite control-port bundle for the instrumentation register file.
// The master modport is the host side; the slave modport is the register file.
interface instr_axilite_regs_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/instr_axilite_regs.sv
// AXI4-Lite responder holding the traffic CFG register (seed, gen/sink enables)
// and exposing the instrumentation counters as read-only words.
module instr_axilite_regs #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    instr_axilite_regs_if.slave       s_axi_ctrl,
    output logic                      cfg_gen_en,
    output logic                      cfg_sink_en,
    output logic [15:0]               cfg_seed,
    output logic                      cfg_start,
    input  logic [31:0]               stat_in_count,
    input  logic [31:0]               stat_out_count,
    input  logic [31:0]               stat_latency,
    input  logic [31:0]               stat_interval,
    input  logic [31:0]               stat_checksum
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CFG      = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS_I = ADDR_WIDTH'(8'h18);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS_O = ADDR_WIDTH'(8'h20);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LATENCY  = ADDR_WIDTH'(8'h28);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INTERVAL = ADDR_WIDTH'(8'h38);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CHECKSUM = ADDR_WIDTH'(8'h48);
    localparam logic [31:0]           CFG_WMASK     = 32'hFFFF_0003;
    localparam logic [1:0]            RESP_OKAY     = 2'b00;
    localparam logic [1:0]            RESP_SLVERR   = 2'b10;

    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic                  w_held_q,  w_held_d;
    logic [31:0]           wdata_q,   wdata_d;
    logic [3:0]            wstrb_q,   wstrb_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic [31:0]           cfg_q,     cfg_d;
    logic                  cfg_start_q, cfg_start_d;
    logic                  rvalid_q,  rvalid_d;
    logic [31:0]           rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;

    logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [31:0]           byte_mask;
    logic [31:0]           cfg_new;
    logic                  wr_is_cfg;
    logic [31:0]           rd_data;
    logic                  rd_err;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(3);
    endfunction

    // Readies are gated by reset so nothing is accepted while ap_rst_n is low.
    assign s_axi_ctrl.awready = ap_rst_n && !aw_held_q && !bvalid_q;
    assign s_axi_ctrl.wready  = ap_rst_n && !w_held_q  && !bvalid_q;
    assign s_axi_ctrl.arready = ap_rst_n && !rvalid_q;
    assign s_axi_ctrl.bvalid  = bvalid_q;
    assign s_axi_ctrl.bresp   = bresp_q;
    assign s_axi_ctrl.rvalid  = rvalid_q;
    assign s_axi_ctrl.rdata   = rdata_q;
    assign s_axi_ctrl.rresp   = rresp_q;

    assign aw_hs = s_axi_ctrl.awvalid && s_axi_ctrl.awready;
    assign w_hs  = s_axi_ctrl.wvalid  && s_axi_ctrl.wready;
    assign ar_hs = s_axi_ctrl.arvalid && s_axi_ctrl.arready;
    assign b_hs  = bvalid_q && s_axi_ctrl.bready;
    assign r_hs  = rvalid_q && s_axi_ctrl.rready;

    // A live handshake stands in for its holding register, so same-edge AW+W commits at once.
    assign wr_addr = aw_held_q ? awaddr_q : s_axi_ctrl.awaddr;
    assign wr_data = w_held_q  ? wdata_q  : s_axi_ctrl.wdata;
    assign wr_strb = w_held_q  ? wstrb_q  : s_axi_ctrl.wstrb;
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
    assign wr_is_cfg = (word_addr(wr_addr) == ADDR_CFG);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
        assign byte_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
    end

    assign cfg_new = ((cfg_q & ~byte_mask) | (wr_data & byte_mask)) & CFG_WMASK;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (word_addr(s_axi_ctrl.araddr))
            ADDR_CFG:      rd_data = cfg_q;
            ADDR_STATUS_I: rd_data = stat_in_count;
            ADDR_STATUS_O: rd_data = stat_out_count;
            ADDR_LATENCY:  rd_data = stat_latency;
            ADDR_INTERVAL: rd_data = stat_interval;
            ADDR_CHECKSUM: rd_data = stat_checksum;
            default:       rd_err  = 1'b1;
        endcase
    end

    always_comb begin
        aw_held_d   = aw_held_q;
        awaddr_d    = awaddr_q;
        w_held_d    = w_held_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        cfg_d       = cfg_q;
        cfg_start_d = 1'b0;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi_ctrl.awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_ctrl.wdata;
            wstrb_d  = s_axi_ctrl.wstrb;
        end

        if (commit) begin
            bvalid_d = 1'b1;
            if (wr_is_cfg) begin
                cfg_d       = cfg_new;
                bresp_d     = RESP_OKAY;
                cfg_start_d = !cfg_q[0] && cfg_new[0];
            end else begin
                bresp_d     = RESP_SLVERR;
            end
        end else if (b_hs) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end

        // Counters are captured at the AR edge; rdata then stays frozen until rready.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            aw_held_q   <= 1'b0;
            awaddr_q    <= '0;
            w_held_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            cfg_q       <= '0;
            cfg_start_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
        end else begin
            aw_held_q   <= aw_held_d;
            awaddr_q    <= awaddr_d;
            w_held_q    <= w_held_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            cfg_q       <= cfg_d;
            cfg_start_q <= cfg_start_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
        end
    end

    assign cfg_gen_en  = cfg_q[0];
    assign cfg_sink_en = cfg_q[1];
    assign cfg_seed    = cfg_q[31:16];
    assign cfg_start   = cfg_start_q;
endmodule

// File: tb/tb_instr_axilite_regs.sv
// Directed and randomized checks of instr_axilite_regs against a register-map model.
module tb_instr_axilite_regs;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        cfg_gen_en, cfg_sink_en, cfg_start;
    logic [15:0] cfg_seed;
    logic [31:0] stat_in_count, stat_out_count, stat_latency, stat_interval, stat_checksum;

    int vectors    = 0;
    int miscompares = 0;
    int start_cnt  = 0;
    logic [31:0] cfg_m;

    instr_axilite_regs_if #(.ADDR_WIDTH(8)) axi ();

    instr_axilite_regs #(.ADDR_WIDTH(8)) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .s_axi_ctrl     (axi.slave),
        .cfg_gen_en     (cfg_gen_en),
        .cfg_sink_en    (cfg_sink_en),
        .cfg_seed       (cfg_seed),
        .cfg_start      (cfg_start),
        .stat_in_count  (stat_in_count),
        .stat_out_count (stat_out_count),
        .stat_latency   (stat_latency),
        .stat_interval  (stat_interval),
        .stat_checksum  (stat_checksum)
    );

    always #5 ap_clk = ~ap_clk;

    always @(negedge ap_clk) if (cfg_start === 1'b1) start_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Register-map model: byte-lane merge with only seed/enable bits writable.
    function automatic logic [31:0] merge_cfg(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r & 32'hFFFF_0003;
    endfunction

    task automatic exp_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] resp);
        resp = 2'b00;
        case (addr >> 2)
            8'h04:   d = cfg_m;
            8'h06:   d = stat_in_count;
            8'h08:   d = stat_out_count;
            8'h0A:   d = stat_latency;
            8'h0E:   d = stat_interval;
            8'h12:   d = stat_checksum;
            default: begin d = 32'h0; resp = 2'b10; end
        endcase
    endtask

    task automatic chk_cfg(input string tag);
        chk({tag, "_gen"},  32'(cfg_gen_en),  32'(cfg_m[0]));
        chk({tag, "_sink"}, 32'(cfg_sink_en), 32'(cfg_m[1]));
        chk({tag, "_seed"}, 32'(cfg_seed),    32'(cfg_m[31:16]));
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_now, w_now;
        int n;
        axi.awaddr = addr; axi.awvalid = 1'b1;
        axi.wdata = data;  axi.wstrb = strb; axi.wvalid = 1'b1;
        axi.bready = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = axi.awvalid && axi.awready;
            w_now  = axi.wvalid && axi.wready;
            step();
            if (aw_now) begin aw_done = 1; axi.awvalid = 1'b0; end
            if (w_now)  begin w_done = 1;  axi.wvalid  = 1'b0; end
            n++;
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        n = 0;
        while (axi.bvalid !== 1'b1 && n < 20) begin step(); n++; end
        chk("wr_bvalid", 32'(axi.bvalid), 1);
        resp = axi.bresp;
        step();
        axi.bready = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0]  resp, eresp;
        logic [31:0] nxt;
        int s0, es;
        s0 = start_cnt;
        eresp = 2'b10; es = 0; nxt = cfg_m;
        if ((addr >> 2) == 8'h04) begin
            eresp = 2'b00;
            nxt = merge_cfg(cfg_m, data, strb);
            es = (!cfg_m[0] && nxt[0]) ? 1 : 0;
        end
        axi_write(addr, data, strb, resp);
        cfg_m = nxt;
        $display("wr addr=%02h data=%08h strb=%h bresp=%0d", addr, data, strb, resp);
        chk("wr_bresp", 32'(resp), 32'(eresp));
        chk("wr_start", 32'(start_cnt - s0), 32'(es));
        chk_cfg("wr_cfg");
    endtask

    task automatic do_read(input logic [7:0] addr);
        logic [31:0] ed;
        logic [1:0]  er;
        int n;
        axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
        n = 0;
        while (axi.arready !== 1'b1 && n < 20) begin step(); n++; end
        exp_read(addr, ed, er);
        step();
        axi.arvalid = 1'b0;
        chk("rd_rvalid", 32'(axi.rvalid), 1);
        chk("rd_rdata", axi.rdata, ed);
        chk("rd_rresp", 32'(axi.rresp), 32'(er));
        $display("rd addr=%02h rdata=%08h rresp=%0d", addr, axi.rdata, axi.rresp);
        step();
        axi.rready = 1'b0;
        chk("rd_rvalid_drop", 32'(axi.rvalid), 0);
    endtask

    // Two-phase write with a gap between AW and W and a stalled B channel.
    task automatic split_write(input bit w_first, input logic [7:0] addr, input logic [31:0] data);
        int s0, es;
        logic [31:0] nxt;
        s0 = start_cnt;
        nxt = merge_cfg(cfg_m, data, 4'hF);
        es = (!cfg_m[0] && nxt[0]) ? 1 : 0;
        axi.awaddr = addr; axi.wdata = data; axi.wstrb = 4'hF; axi.bready = 1'b0;
        if (w_first) axi.wvalid = 1'b1; else axi.awvalid = 1'b1;
        step();
        axi.wvalid = 1'b0; axi.awvalid = 1'b0;
        chk("split_first_held", w_first ? 32'(axi.wready) : 32'(axi.awready), 0);
        step();
        chk("split_no_commit", 32'(axi.bvalid), 0);
        if (w_first) axi.awvalid = 1'b1; else axi.wvalid = 1'b1;
        step();
        axi.wvalid = 1'b0; axi.awvalid = 1'b0;
        cfg_m = nxt;
        for (int i = 0; i < 3; i++) begin
            chk("split_bvalid_hold", 32'(axi.bvalid), 1);
            chk("split_awready_blk", 32'(axi.awready), 0);
            chk("split_wready_blk", 32'(axi.wready), 0);
            step();
        end
        chk("split_bresp", 32'(axi.bresp), 0);
        axi.bready = 1'b1;
        step();
        axi.bready = 1'b0;
        chk("split_bvalid_clr", 32'(axi.bvalid), 0);
        chk("split_start", 32'(start_cnt - s0), 32'(es));
        chk_cfg("split_cfg");
        $display("split wr w_first=%0d data=%08h", w_first, data);
    endtask

    initial begin
        logic [7:0]  stream_addr [5];
        logic [31:0] stream_data [5];
        logic [7:0]  rnd_addr [8];
        logic [7:0]  a;
        logic [31:0] old;
        int s0, n;

        ap_rst_n = 1'b0;
        axi.awvalid = 0; axi.wvalid = 0; axi.bready = 0; axi.arvalid = 0; axi.rready = 0;
        axi.awaddr = 0; axi.wdata = 0; axi.wstrb = 0; axi.araddr = 0;
        stat_in_count = 0; stat_out_count = 0; stat_latency = 0; stat_interval = 0; stat_checksum = 0;
        cfg_m = 32'h0;
        repeat (3) step();
        chk("rst_awready", 32'(axi.awready), 0);
        chk("rst_wready", 32'(axi.wready), 0);
        chk("rst_arready", 32'(axi.arready), 0);
        chk("rst_bvalid", 32'(axi.bvalid), 0);
        chk("rst_rvalid", 32'(axi.rvalid), 0);
        chk("rst_rdata", axi.rdata, 0);
        chk("rst_start", 32'(cfg_start), 0);
        chk_cfg("rst_cfg");
        ap_rst_n = 1'b1;
        step();
        chk("post_rst_awready", 32'(axi.awready), 1);
        chk("post_rst_arready", 32'(axi.arready), 1);

        // First CFG write, AW and W on the same edge, exact timing.
        s0 = start_cnt;
        axi.awaddr = 8'h10; axi.wdata = 32'h0001_0003; axi.wstrb = 4'hF;
        axi.awvalid = 1; axi.wvalid = 1; axi.bready = 0;
        step();
        axi.awvalid = 0; axi.wvalid = 0;
        cfg_m = 32'h0001_0003;
        chk("first_bvalid", 32'(axi.bvalid), 1);
        chk("first_bresp", 32'(axi.bresp), 0);
        chk("first_start_hi", 32'(cfg_start), 1);
        chk_cfg("first_cfg");
        axi.bready = 1;
        step();
        axi.bready = 0;
        chk("first_bvalid_clr", 32'(axi.bvalid), 0);
        chk("first_start_lo", 32'(cfg_start), 0);
        chk("first_start_cnt", 32'(start_cnt - s0), 1);
        do_read(8'h10);

        // Back-to-back status reads with arvalid held high.
        stat_in_count = 32'd5; stat_out_count = 32'd7; stat_latency = 32'h40;
        stat_interval = 32'h20; stat_checksum = 32'h09AB_CDEF;
        stream_addr = '{8'h18, 8'h20, 8'h28, 8'h38, 8'h48};
        stream_data = '{32'd5, 32'd7, 32'h40, 32'h20, 32'h09AB_CDEF};
        axi.arvalid = 1; axi.rready = 1;
        for (int i = 0; i < 5; i++) begin
            axi.araddr = stream_addr[i];
            n = 0;
            while (axi.arready !== 1'b1 && n < 10) begin step(); n++; end
            chk("stream_gap", 32'(n), (i == 0) ? 0 : 1);
            step();
            chk("stream_rvalid", 32'(axi.rvalid), 1);
            chk("stream_rdata", axi.rdata, stream_data[i]);
            chk("stream_rresp", 32'(axi.rresp), 0);
            chk("stream_arready", 32'(axi.arready), 0);
            $display("stream rd addr=%02h rdata=%08h", stream_addr[i], axi.rdata);
        end
        axi.arvalid = 0;
        step();
        chk("stream_end_rvalid", 32'(axi.rvalid), 0);
        axi.rready = 0;

        split_write(1'b1, 8'h10, 32'h1234_0002);
        split_write(1'b0, 8'h10, 32'h5678_0001);

        do_write(8'h18, 32'hFFFF_FFFF, 4'hF);
        do_write(8'h44, 32'hFFFF_FFFF, 4'hF);
        do_read(8'h44);

        do_write(8'h10, 32'h0000_0003, 4'hF);
        do_write(8'h10, 32'h0000_0001, 4'hF);
        do_write(8'h10, 32'hBEEF_0000, 4'b1100);
        chk("beef_seed", 32'(cfg_seed), 32'hBEEF);

        // Same-edge CFG read and CFG commit: read sees the old value.
        old = cfg_m;
        axi.araddr = 8'h10; axi.arvalid = 1; axi.rready = 0;
        axi.awaddr = 8'h12; axi.wdata = 32'h00AA_0000; axi.wstrb = 4'hF;
        axi.awvalid = 1; axi.wvalid = 1; axi.bready = 0;
        step();
        axi.arvalid = 0; axi.awvalid = 0; axi.wvalid = 0;
        cfg_m = merge_cfg(cfg_m, 32'h00AA_0000, 4'hF);
        chk("same_edge_rdata", axi.rdata, old);
        chk("same_edge_bvalid", 32'(axi.bvalid), 1);
        chk_cfg("same_edge_cfg");
        axi.rready = 1; axi.bready = 1;
        step();
        axi.rready = 0; axi.bready = 0;
        chk("same_edge_rclr", 32'(axi.rvalid), 0);
        chk("same_edge_bclr", 32'(axi.bvalid), 0);

        // Status captured at AR edge; later counter change must not leak in.
        stat_latency = 32'h0000_0111;
        axi.araddr = 8'h29; axi.arvalid = 1; axi.rready = 0;
        n = 0;
        while (axi.arready !== 1'b1 && n < 10) begin step(); n++; end
        step();
        axi.arvalid = 0;
        stat_latency = 32'h0000_0222;
        step(); step();
        chk("hold_rvalid", 32'(axi.rvalid), 1);
        chk("hold_rdata", axi.rdata, 32'h0000_0111);
        axi.rready = 1;
        step();
        axi.rready = 0;

        rnd_addr = '{8'h10, 8'h13, 8'h18, 8'h20, 8'h2A, 8'h38, 8'h4B, 8'h44};
        for (int t = 0; t < 150; t++) begin
            stat_in_count = $urandom; stat_out_count = $urandom; stat_latency = $urandom;
            stat_interval = $urandom; stat_checksum = $urandom;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rnd_addr[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom));
            else do_read(a);
        end

        // Reset with a read response pending and an AW held.
        axi.araddr = 8'h18; axi.arvalid = 1; axi.rready = 0;
        step();
        axi.arvalid = 0;
        axi.awaddr = 8'h10; axi.awvalid = 1;
        step();
        axi.awvalid = 0;
        chk("inflight_rvalid", 32'(axi.rvalid), 1);
        chk("inflight_awheld", 32'(axi.awready), 0);
        ap_rst_n = 0;
        #1;
        chk("rstlow_awready", 32'(axi.awready), 0);
        chk("rstlow_wready", 32'(axi.wready), 0);
        chk("rstlow_arready", 32'(axi.arready), 0);
        @(posedge ap_clk); #1;
        cfg_m = 32'h0;
        chk("rst2_rvalid", 32'(axi.rvalid), 0);
        chk("rst2_rdata", axi.rdata, 0);
        chk("rst2_arready", 32'(axi.arready), 0);
        chk_cfg("rst2_cfg");
        ap_rst_n = 1;
        step();
        chk("rel_awready", 32'(axi.awready), 1);
        axi.wdata = 32'h0000_0001; axi.wstrb = 4'hF; axi.wvalid = 1;
        step();
        axi.wvalid = 0;
        chk("rel_no_commit", 32'(axi.bvalid), 0);
        step();
        chk("rel_no_commit2", 32'(axi.bvalid), 0);
        s0 = start_cnt;
        axi.awaddr = 8'h10; axi.awvalid = 1; axi.bready = 1;
        step();
        axi.awvalid = 0;
        cfg_m = 32'h0000_0001;
        chk("rel_commit", 32'(axi.bvalid), 1);
        step();
        axi.bready = 0;
        chk("rel_start", 32'(start_cnt - s0), 1);
        chk_cfg("rel_cfg");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_axilite_regs.md
# instr_axilite_regs

AXI4-Lite responder (slave) register file of the instrumentation wrapper: the endpoint the host or testbench polls to configure the traffic generator/sink and read back performance counters. It holds the writable configuration register (LFSR seed, generator enable, sink enable) and presents the instrumentation counters as read-only registers. It sits between the wrapper's `s_axi_ctrl` port and the generator, sink and counter logic inside the wrapper.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of `awaddr`/`araddr`; only bits [ADDR_WIDTH-1:0] are decoded.

Ports:
- ap_clk  in  1  sole clock; all logic on its rising edge.
- ap_rst_n  in  1  reset, synchronous and active-low.
- s_axi_ctrl_awaddr  in  ADDR_WIDTH  write address.
- s_axi_ctrl_awvalid / s_axi_ctrl_awready  in / out  1  write-address handshake.
- s_axi_ctrl_wdata  in  32  write data.
- s_axi_ctrl_wstrb  in  4  byte strobes.
- s_axi_ctrl_wvalid / s_axi_ctrl_wready  in / out  1  write-data handshake.
- s_axi_ctrl_bresp  out  2  write response.
- s_axi_ctrl_bvalid / s_axi_ctrl_bready  out / in  1  write-response handshake.
- s_axi_ctrl_araddr  in  ADDR_WIDTH  read address.
- s_axi_ctrl_arvalid / s_axi_ctrl_arready  in / out  1  read-address handshake.
- s_axi_ctrl_rdata  out  32  read data.
- s_axi_ctrl_rresp  out  2  read response.
- s_axi_ctrl_rvalid / s_axi_ctrl_rready  out / in  1  read-data handshake.
- cfg_gen_en  out  1  CFG[0].
- cfg_sink_en  out  1  CFG[1].
- cfg_seed  out  16  CFG[31:16].
- cfg_start  out  1  one-cycle pulse when a write sets CFG[0] from 0 to 1.
- stat_in_count  in  32  STATUS_I counter.
- stat_out_count  in  32  STATUS_O counter.
- stat_latency  in  32  LATENCY counter.
- stat_interval  in  32  INTERVAL counter.
- stat_checksum  in  32  CHECKSUM; [31:24] holds the frame index.

## Operation
- Register map (byte offsets):
  - 0x10 CFG, RW: [0] gen_en, [1] sink_en, [31:16] seed; [15:2] read as 0.
  - 0x18 STATUS_I, RO.
  - 0x20 STATUS_O, RO.
  - 0x28 LATENCY, RO.
  - 0x38 INTERVAL, RO.
  - 0x48 CHECKSUM, RO.
- Write path:
  - AW and W are accepted independently and in either order; each is latched into a holding register.
  - The write commits on the edge where both are held, or on the edge where the second one handshakes; if both handshake on the same edge, the write commits on that edge.
  - On commit, `wstrb` masks each byte of CFG and bvalid rises.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - bvalid holds until bready; the held flags clear on the B handshake.
- Write responses:
  - Write to CFG: bresp OKAY (00).
  - Write to a RO or unmapped offset: bresp SLVERR (10), no state change.
- Read path:
  - arready = !rvalid.
  - On the AR handshake, rdata/rresp are registered from the decoded address and rvalid rises.
  - rvalid holds, with rdata stable, until rready.
  - Unmapped offset: rdata 0, rresp SLVERR.
- Address decoding ignores bits [1:0]; unaligned addresses alias to their word.
- cfg_start asserts for exactly one cycle after a commit where old CFG[0]=0 and new CFG[0]=1. A write that keeps bit0 at 1 produces no pulse.
- Reset (ap_rst_n low at an edge):
  - CFG=0; cfg_* outputs 0; bvalid, rvalid and held flags 0; rdata 0; bresp/rresp 00.
  - awready, wready and arready are forced 0 while ap_rst_n is low.
  - A transaction in flight is dropped; the responder does not complete it.

## Timing
- Read latency: AR handshake at edge N → rvalid=1 from edge N to N+1. With rready tied 1, arready is back to 1 after edge N+1, giving one read per 2 cycles.
- Write latency: AW and W handshake together at edge N → CFG and cfg_* updated at N, bvalid=1 after N, cfg_start high for cycle N..N+1.
- Status values are sampled at the AR handshake edge; later counter changes do not alter a pending rdata.
- Same-edge read of CFG and commit to CFG: the read returns the pre-write value.
- Read and write channels run concurrently; neither blocks the other.

## Test plan
- Reset, then write 0x10 with wdata 0x0001_0003, wstrb 1111, AW/W together → bresp 00 one cycle later, cfg_seed=0x0001, gen_en=sink_en=1, a single cfg_start pulse; read 0x10 → 0x0001_0003.
- Drive stat_* = 5, 7, 0x40, 0x20, 0x09AB_CDEF; hold arvalid=1, rready=1 and step araddr through 0x18/0x20/0x28/0x38/0x48 → rvalid on the cycle after each accept, data matching in order, rresp 00.
- W two cycles before AW (and the reverse), with bready low for 3 cycles → single commit, bvalid stays high until bready, no second accept while bvalid=1.
- Write 0x18 and 0x44; read 0x44 → bresp 10 with CFG unchanged; rdata 0 with rresp 10.
- Write CFG=0x3 again while gen_en=1 → no cfg_start. Then wstrb=1100, wdata 0xBEEF_0000 → seed=0xBEEF, bits [1:0] unchanged.
- Assert ap_rst_n low while rvalid=1 and the AW is held → next cycle rvalid=0, held flag cleared, CFG=0, all readies 0 until reset releases.
